// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way set-associative cache controller:
// controller states, default geometry and address-field width helpers.
package cache_pkg;

  localparam int unsigned DEF_SETS      = 64;
  localparam int unsigned DEF_BLK_WORDS = 2;
  localparam int unsigned DEF_TAG_W     = 10;
  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE
  } state_t;

  // Word-offset field width; a one-word line still carries a 1-bit field tied to 0.
  function automatic int unsigned off_w(input int unsigned blk_words);
    return (blk_words > 1) ? $clog2(blk_words) : 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // Bit position of the tag field within the word address.
  function automatic int unsigned tag_lsb(input int unsigned blk_words,
                                          input int unsigned sets);
    return $clog2(blk_words) + $clog2(sets);
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// Storage for one cache way: per-set valid bit, tag and line, with an
// asynchronous read port and a single synchronous write port.
module cache_way_array
  import cache_pkg::*;
#(
  parameter  int unsigned SETS      = DEF_SETS,
  parameter  int unsigned BLK_WORDS = DEF_BLK_WORDS,
  parameter  int unsigned TAG_W     = DEF_TAG_W,
  localparam int unsigned IDX_W     = idx_w(SETS),
  localparam int unsigned LINE_W    = 32 * BLK_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line
);

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags  [SETS];
  logic [LINE_W-1:0] lines [SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage is deliberately not reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      lines[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = lines[rd_index];

endmodule

// File: rtl/assoc_cache_ctrl.sv
// 2-way set-associative read cache in front of an SRAM controller:
// same-cycle read hits, line fill on read miss, write-through with hit update.
module assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned SETS      = DEF_SETS,
  parameter int unsigned BLK_WORDS = DEF_BLK_WORDS,
  parameter int unsigned TAG_W     = DEF_TAG_W,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    MEM_R_EN,
  input  logic                    MEM_W_EN,
  input  logic [31:0]             address,
  input  logic [31:0]             wdata,
  input  logic [32*BLK_WORDS-1:0] sram_rdata,
  input  logic                    sram_ready,
  output logic [31:0]             sram_address,
  output logic [31:0]             sram_wdata,
  output logic                    read_enb,
  output logic                    write_enb,
  output logic [31:0]             rdata,
  output logic                    ready,
  output logic [15:0]             hit_count,
  output logic [15:0]             miss_count
);

  localparam int unsigned OFF_W    = off_w(BLK_WORDS);
  localparam int unsigned OFF_BITS = $clog2(BLK_WORDS);
  localparam int unsigned IDX_W    = idx_w(SETS);
  localparam int unsigned TAG_LSB  = tag_lsb(BLK_WORDS, SETS);
  localparam int unsigned LINE_W   = 32 * BLK_WORDS;

  state_t state;
  state_t next_state;

  logic [31:0]      word_addr;
  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_index;
  logic [TAG_W-1:0] req_tag;

  logic [OFF_W-1:0] fill_off;
  logic [IDX_W-1:0] fill_index;
  logic [TAG_W-1:0] fill_tag;

  logic [SETS-1:0]  lru;

  logic [IDX_W-1:0]  look_index;
  logic              way_valid [2];
  logic [TAG_W-1:0]  way_tag   [2];
  logic [LINE_W-1:0] way_line  [2];
  logic [1:0]        hit;
  logic              hit_any;
  logic              hit_way;
  logic [LINE_W-1:0] hit_line;
  logic              victim;

  logic              do_hit_read;
  logic              do_fill;
  logic              do_write_hit;
  logic [1:0]        wr_en;
  logic [IDX_W-1:0]  wr_index;
  logic [TAG_W-1:0]  wr_tag;
  logic [LINE_W-1:0] wr_line;
  logic [LINE_W-1:0] wr_merge;

  assign word_addr = (address - BASE_ADDR) >> 2;
  assign req_off   = (BLK_WORDS > 1) ? OFF_W'(word_addr) : '0;
  assign req_index = IDX_W'(word_addr >> OFF_BITS);
  assign req_tag   = TAG_W'(word_addr >> TAG_LSB);

  assign sram_address = address;
  assign sram_wdata   = wdata;

  // During a fill the arrays are looked up with the latched miss index so the
  // victim choice does not depend on a requester that may have moved on.
  assign look_index = (state == ST_FILL) ? fill_index : req_index;

  cache_way_array #(
    .SETS      (SETS),
    .BLK_WORDS (BLK_WORDS),
    .TAG_W     (TAG_W)
  ) u_way0 (
    .clk      (clk),
    .rst      (rst),
    .rd_index (look_index),
    .rd_valid (way_valid[0]),
    .rd_tag   (way_tag[0]),
    .rd_line  (way_line[0]),
    .wr_en    (wr_en[0]),
    .wr_index (wr_index),
    .wr_tag   (wr_tag),
    .wr_line  (wr_line)
  );

  cache_way_array #(
    .SETS      (SETS),
    .BLK_WORDS (BLK_WORDS),
    .TAG_W     (TAG_W)
  ) u_way1 (
    .clk      (clk),
    .rst      (rst),
    .rd_index (look_index),
    .rd_valid (way_valid[1]),
    .rd_tag   (way_tag[1]),
    .rd_line  (way_line[1]),
    .wr_en    (wr_en[1]),
    .wr_index (wr_index),
    .wr_tag   (wr_tag),
    .wr_line  (wr_line)
  );

  assign hit[0]   = way_valid[0] && (way_tag[0] == req_tag);
  assign hit[1]   = way_valid[1] && (way_tag[1] == req_tag);
  assign hit_any  = |hit;
  assign hit_way  = hit[1];
  assign hit_line = hit_way ? way_line[1] : way_line[0];

  always_comb begin
    if (!way_valid[0]) begin
      victim = 1'b0;
    end else if (!way_valid[1]) begin
      victim = 1'b1;
    end else begin
      victim = lru[fill_index];
    end
  end

  always_comb begin
    wr_merge = hit_line;
    wr_merge[32*int'(req_off) +: 32] = wdata;
  end

  always_comb begin
    next_state   = state;
    read_enb     = 1'b0;
    write_enb    = 1'b0;
    ready        = 1'b0;
    rdata        = '0;
    do_hit_read  = 1'b0;
    do_fill      = 1'b0;
    do_write_hit = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (MEM_W_EN) begin
            write_enb = 1'b1;
            ready     = sram_ready;
            if (sram_ready) begin
              do_write_hit = hit_any;
            end else begin
              next_state = ST_WRITE;
            end
          end else if (MEM_R_EN) begin
            if (hit_any) begin
              ready       = 1'b1;
              rdata       = hit_line[32*int'(req_off) +: 32];
              do_hit_read = 1'b1;
            end else begin
              read_enb   = 1'b1;
              next_state = ST_FILL;
            end
          end else begin
            ready = 1'b1;
          end
        end
        ST_FILL: begin
          read_enb = 1'b1;
          ready    = sram_ready;
          rdata    = sram_rdata[32*int'(fill_off) +: 32];
          if (sram_ready) begin
            do_fill    = 1'b1;
            next_state = ST_IDLE;
          end
        end
        ST_WRITE: begin
          write_enb = 1'b1;
          ready     = sram_ready;
          if (sram_ready) begin
            do_write_hit = hit_any;
            next_state   = ST_IDLE;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  assign wr_en[0] = (do_fill && !victim) || (do_write_hit && hit[0]);
  assign wr_en[1] = (do_fill &&  victim) || (do_write_hit && hit[1]);
  assign wr_index = do_fill ? fill_index : req_index;
  assign wr_tag   = do_fill ? fill_tag   : req_tag;
  assign wr_line  = do_fill ? sram_rdata : wr_merge;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lru        <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      fill_off   <= '0;
      fill_index <= '0;
      fill_tag   <= '0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && next_state == ST_FILL) begin
        fill_off   <= req_off;
        fill_index <= req_index;
        fill_tag   <= req_tag;
      end
      if (do_hit_read || do_write_hit) begin
        lru[req_index] <= ~hit_way;
      end
      if (do_fill) begin
        lru[fill_index] <= ~victim;
      end
      if (do_hit_read && hit_count != 16'hFFFF) begin
        hit_count <= hit_count + 16'd1;
      end
      if (do_fill && miss_count != 16'hFFFF) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end

endmodule
